dcache_wt_controller: RTL and testbench
=======================================

// Module: dcache_wt_controller
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the RISC-V core's
//  load/store port and the 4-cycle, block-read/word-write main memory. It serves load
//  hits in zero wait states. It stalls the core on load misses (block refill) and on
//  every store, because each store is written through to memory.
// PARAMETERS
//  NUM_LINES   32  cache lines; power of 2; INDEX_W = log2(NUM_LINES) = 5
//  ADDR_W      10  word-address width; TAG_W = ADDR_W - INDEX_W - 2 = 3
//  DATA_W      32  word width; one line = 4 words = 128 bits
// PORTS
//  clk            in   1    clock, rising edge
//  rst_n          in   1    reset, asynchronous, active-low
//  cpu_read       in   1    load request (held while stall=1)
//  cpu_write      in   1    store request (held while stall=1)
//  cpu_addr       in   10   word address: tag[9:7] index[6:2] offset[1:0]
//  cpu_wdata      in   32   store data
//  cpu_rdata      out  32   load data; valid when cpu_read=1 and stall=0
//  stall          out  1    core must hold its request and freeze
//  mem_read       out  1    block read request to main memory
//  mem_write      out  1    word write request to main memory
//  mem_word_addr  out  10   word address to memory (latched)
//  mem_wdata      out  32   store data to memory (latched)
//  mem_block_in   in   128  refill block, word0 in [31:0]; valid while mem_ready=1
//  mem_ready      in   1    memory done; 1-cycle pulse, raised by the 4th clock edge of a held request
// BEHAVIOUR
//  Reset: all valid bits=0, state=IDLE, stall=0, mem_read=0, mem_write=0, mem_word_addr=0,
//   mem_wdata=0, cpu_rdata=0. Tag and data arrays are not reset. Reset mid-operation
//   aborts the operation with no partial line fill; memory shares rst_n.
//  hit = valid[index] && tag_arr[index]==tag (combinational).
//  States: IDLE, RD_MISS, WR_THRU.
//  IDLE, cpu_write=1 (priority over read): stall=1. On a hit, the word is written into the
//   line at this edge. Latch addr/data and go to WR_THRU. A miss does not allocate.
//  IDLE, cpu_read=1 and hit: cpu_rdata=line word[offset] combinationally, stall=0.
//  IDLE, cpu_read=1 and miss: stall=1; latch addr; go to RD_MISS.
//  RD_MISS: stall=1; mem_read = !mem_ready. On mem_ready, write mem_block_in to the line,
//   set tag and valid, and go to IDLE. The held load then hits.
//  WR_THRU: mem_write = !mem_ready; stall = !mem_ready. On mem_ready, go to IDLE. The core
//   retires the store in that cycle, and the still-asserted cpu_write is ignored there.
//  Requests must drop in the mem_ready cycle; otherwise the memory counter overruns.
//  Timing (cycle 0 = request seen in IDLE):
//   Load miss: mem_read in cycles 1-4; mem_ready in cycle 5; stall=1 in cycles 0-5;
//    data in cycle 6 with stall=0.
//   Store: mem_write in cycles 1-4; memory written at the end of cycle 4; stall=1 in
//    cycles 0-4.
//  Address fields are unsigned slices; no arithmetic beyond tag/index compare.
//  cpu_read=cpu_write=0 in IDLE: no state change, stall=0.
// STRUCTURE
//  Shared package cache_pkg: state encoding, TAG_W/INDEX_W/OFFSET_W localparams,
//   address-field slice helpers.
//  Sub-module cache_line_array: valid/tag/data storage, async-reset valid bits,
//   combinational read, one line-fill port and one word-write port.
// TESTING
//  1 Reset; load 0x004 (mem[4]=0x11111111) -> stall cycles 0-5, mem_read cycles 1-4,
//    cpu_rdata=0x11111111 in cycle 6.
//  2 Then load 0x005 (mem[5]=0x22222222) -> hit: stall=0 in the same cycle, rdata=0x22222222.
//  3 Store 0x006=0xDEADBEEF (hit) -> stall cycles 0-4, mem[6]=0xDEADBEEF;
//    then load 0x006 hits with 0xDEADBEEF.
//  4 Store 0x100=0xCAFEF00D (miss) -> mem[0x100] is updated and no line is allocated;
//    then load 0x100 misses (6 stall cycles).
//  5 Load 0x000 then 0x080 (same index, tag 0 vs 1) -> both miss; a reload of 0x000
//    misses again.
//  6 Assert rst_n=0 in cycle 3 of a load miss -> outputs at reset values immediately;
//    valid is cleared, so the retried load misses.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cache_pkg: geometry, FSM encoding and address-field helpers           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cache_pkg;
   localparam int NUM_LINES = 32;
   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 32;
   localparam int OFFSET_W  = 2;
   localparam int INDEX_W   = $clog2(NUM_LINES);
   localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_W    = DATA_W << OFFSET_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_MISS = 2'd1,
      ST_WR_THRU = 2'd2
   } state_t;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INDEX_W-1:0]  index;
      logic [OFFSET_W-1:0] offset;
   } addr_fields_t;

   function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
      return addr_fields_t'(addr);
   endfunction

   function automatic logic [DATA_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFFSET_W-1:0] offset);
      return line[int'(offset)*DATA_W +: DATA_W];
   endfunction
endpackage
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cache_line_array: valid/tag/data storage, combinational read port     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cache_line_array
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INDEX_W-1:0]  rd_index,
   output logic                rd_valid,
   output logic [TAG_W-1:0]    rd_tag,
   output logic [LINE_W-1:0]   rd_line,
   input  logic                fill_en,
   input  logic [INDEX_W-1:0]  fill_index,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [LINE_W-1:0]   fill_line,
   input  logic                wr_en,
   input  logic [INDEX_W-1:0]  wr_index,
   input  logic [OFFSET_W-1:0] wr_offset,
   input  logic [DATA_W-1:0]   wr_data
);
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
   logic [LINE_W-1:0]    data_arr [NUM_LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid <= '0;
      else if (fill_en)
         valid[fill_index] <= 1'b1;
   end

   // Tag and data are left unreset; the valid bit alone qualifies them.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_arr[fill_index]  <= fill_tag;
         data_arr[fill_index] <= fill_line;
      end else if (wr_en) begin
         data_arr[wr_index][int'(wr_offset)*DATA_W +: DATA_W] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_arr[rd_index];
   assign rd_line  = data_arr[rd_index];
endmodule
`default_nettype wire

// File: rtl/dcache_wt_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dcache_wt_controller: direct-mapped write-through no-allocate D-cache |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dcache_wt_controller
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              stall,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_word_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_block_in,
   input  logic              mem_ready
);
   state_t       state;
   addr_fields_t req;
   addr_fields_t lat;
   logic         line_valid;
   logic [TAG_W-1:0]  line_tag;
   logic [LINE_W-1:0] line_data;
   logic         hit;
   logic         fill_en;
   logic         wr_en;

   assign req     = split_addr(cpu_addr);
   assign lat     = split_addr(mem_word_addr);
   assign hit     = line_valid && (line_tag == req.tag);
   assign fill_en = (state == ST_RD_MISS) && mem_ready;
   assign wr_en   = (state == ST_IDLE) && cpu_write && hit;

   cache_line_array u_lines (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_index   (req.index),
      .rd_valid   (line_valid),
      .rd_tag     (line_tag),
      .rd_line    (line_data),
      .fill_en    (fill_en),
      .fill_index (lat.index),
      .fill_tag   (lat.tag),
      .fill_line  (mem_block_in),
      .wr_en      (wr_en),
      .wr_index   (req.index),
      .wr_offset  (req.offset),
      .wr_data    (cpu_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         mem_word_addr <= '0;
         mem_wdata     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_write) begin
                  mem_word_addr <= cpu_addr;
                  mem_wdata     <= cpu_wdata;
                  state         <= ST_WR_THRU;
               end else if (cpu_read && !hit) begin
                  mem_word_addr <= cpu_addr;
                  state         <= ST_RD_MISS;
               end
            end
            ST_RD_MISS, ST_WR_THRU: begin
               if (mem_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Handshake outputs are gated by rst_n so they read as idle during reset.
   always_comb begin
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      cpu_rdata = '0;
      if (rst_n) begin
         case (state)
            ST_IDLE: begin
               stall = cpu_write || (cpu_read && !hit);
               if (cpu_read && !cpu_write && hit)
                  cpu_rdata = line_word(line_data, req.offset);
            end
            ST_RD_MISS: begin
               stall    = 1'b1;
               mem_read = !mem_ready;
            end
            ST_WR_THRU: begin
               stall     = !mem_ready;
               mem_write = !mem_ready;
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dcache_wt_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dcache_wt_controller: scoreboard bench with 4-cycle memory model   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_dcache_wt_controller;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_read = 1'b0;
   logic          cpu_write = 1'b0;
   logic [9:0]    cpu_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic [31:0]   cpu_rdata;
   logic          stall;
   logic          mem_read;
   logic          mem_write;
   logic [9:0]    mem_word_addr;
   logic [31:0]   mem_wdata;
   logic [127:0]  mem_block_in;
   logic          mem_ready;

   int compared = 0;
   int mismatched = 0;
   logic [31:0] exp_q[$];

   logic [31:0] mem [1024];
   bit          written [1024];
   logic [31:0] gold [1024];
   bit          gold_w [1024];
   int unsigned cnt;

   dcache_wt_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_read      (cpu_read),
      .cpu_write     (cpu_write),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_rdata     (cpu_rdata),
      .stall         (stall),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_word_addr (mem_word_addr),
      .mem_wdata     (mem_wdata),
      .mem_block_in  (mem_block_in),
      .mem_ready     (mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [9:0] a);
      if (a == 10'h004) return 32'h1111_1111;
      if (a == 10'h005) return 32'h2222_2222;
      return 32'h5A00_0000 | {22'd0, a};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [9:0] a);
      return written[a] ? mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] gold_rd(input logic [9:0] a);
      return gold_w[a] ? gold[a] : init_val(a);
   endfunction

   function automatic logic [127:0] blk(input logic [9:0] a);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) b[i*32 +: 32] = mem_rd({a[9:2], 2'(i)});
      return b;
   endfunction

   // Memory: ready pulses after the 4th edge with a request held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 0; mem_ready <= 1'b0; mem_block_in <= '0;
      end else if (mem_ready) begin
         cnt <= 0; mem_ready <= 1'b0; mem_block_in <= '0;
      end else if (mem_read || mem_write) begin
         if (cnt == 3) begin
            cnt <= 0;
            mem_ready <= 1'b1;
            mem_block_in <= blk(mem_word_addr);
            if (mem_write) begin
               mem[mem_word_addr] <= mem_wdata;
               written[mem_word_addr] <= 1'b1;
            end
         end else begin
            cnt <= cnt + 1;
         end
      end else begin
         cnt <= 0;
      end
   end

   task automatic do_load(input logic [9:0] addr, output int lat, output logic [7:0] smask,
                          output logic [7:0] rmask, output logic [31:0] rdata,
                          output logic [9:0] addr_c1);
      @(negedge clk);
      cpu_read = 1'b1; cpu_addr = addr;
      exp_q.push_back(gold_rd(addr));
      lat = -1; smask = '0; rmask = '0; rdata = '0; addr_c1 = '0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (c < 8) begin smask[c] = stall; rmask[c] = mem_read; end
         if (c == 1) addr_c1 = mem_word_addr;
         if (!stall) begin lat = c; rdata = cpu_rdata; break; end
         @(negedge clk);
      end
      cpu_read = 1'b0;
   endtask

   task automatic do_store(input logic [9:0] addr, input logic [31:0] data, output int lat,
                           output logic [7:0] smask, output logic [7:0] wmask);
      @(negedge clk);
      cpu_write = 1'b1; cpu_addr = addr; cpu_wdata = data;
      gold[addr] = data; gold_w[addr] = 1'b1;
      exp_q.push_back(data);
      lat = -1; smask = '0; wmask = '0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (c < 8) begin smask[c] = stall; wmask[c] = mem_write; end
         if (!stall) begin lat = c; break; end
         @(negedge clk);
      end
      cpu_write = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      compared++;
      if ({stall, mem_read, mem_write} !== 3'b000) begin
         mismatched++; $display("FAIL reset_ctrl: got %b want 000", {stall, mem_read, mem_write});
      end
      compared++;
      if ({mem_word_addr, mem_wdata, cpu_rdata} !== 74'd0) begin
         mismatched++;
         $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want all zero", mem_word_addr, mem_wdata, cpu_rdata);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL idle_stall: got %b want 0", stall); end
   endtask

   task automatic test_load_miss(input logic [9:0] addr, input string tag);
      int lat; logic [7:0] sm, rm; logic [31:0] rd, exp; logic [9:0] a1;
      do_load(addr, lat, sm, rm, rd, a1);
      exp = exp_q.pop_front();
      compared++;
      if (lat !== 6) begin mismatched++; $display("FAIL %s_lat: got %0d want 6", tag, lat); end
      compared++;
      if (sm !== 8'h3F) begin mismatched++; $display("FAIL %s_stall: got %h want 3f", tag, sm); end
      compared++;
      if (rm !== 8'h1E) begin mismatched++; $display("FAIL %s_mem_read: got %h want 1e", tag, rm); end
      compared++;
      if (a1 !== addr) begin mismatched++; $display("FAIL %s_mem_addr: got %h want %h", tag, a1, addr); end
      compared++;
      if (rd !== exp) begin mismatched++; $display("FAIL %s_data: got %h want %h", tag, rd, exp); end
   endtask

   task automatic test_load_hit(input logic [9:0] addr, input string tag);
      int lat; logic [7:0] sm, rm; logic [31:0] rd, exp; logic [9:0] a1;
      do_load(addr, lat, sm, rm, rd, a1);
      exp = exp_q.pop_front();
      compared++;
      if (lat !== 0) begin mismatched++; $display("FAIL %s_lat: got %0d want 0", tag, lat); end
      compared++;
      if (rd !== exp) begin mismatched++; $display("FAIL %s_data: got %h want %h", tag, rd, exp); end
   endtask

   task automatic test_store(input logic [9:0] addr, input logic [31:0] data, input string tag);
      int lat; logic [7:0] sm, wm; logic [31:0] exp;
      do_store(addr, data, lat, sm, wm);
      exp = exp_q.pop_front();
      compared++;
      if (lat !== 5) begin mismatched++; $display("FAIL %s_lat: got %0d want 5", tag, lat); end
      compared++;
      if (sm !== 8'h1F) begin mismatched++; $display("FAIL %s_stall: got %h want 1f", tag, sm); end
      compared++;
      if (wm !== 8'h1E) begin mismatched++; $display("FAIL %s_mem_write: got %h want 1e", tag, wm); end
      compared++;
      if (mem_rd(addr) !== exp) begin
         mismatched++; $display("FAIL %s_mem: got %h want %h", tag, mem_rd(addr), exp);
      end
   endtask

   task automatic test_reset_mid_miss();
      @(negedge clk);
      cpu_read = 1'b1; cpu_addr = 10'h104;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      if ({stall, mem_read, mem_write} !== 3'b000) begin
         mismatched++; $display("FAIL midrst_ctrl: got %b want 000", {stall, mem_read, mem_write});
      end
      compared++;
      if ({mem_word_addr, mem_wdata, cpu_rdata} !== 74'd0) begin
         mismatched++;
         $display("FAIL midrst_data: addr=%h wdata=%h rdata=%h want all zero", mem_word_addr, mem_wdata, cpu_rdata);
      end
      cpu_read = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      test_load_miss(10'h104, "retry_104");
      test_load_miss(10'h004, "retry_004");
   endtask

   initial begin
      test_reset();
      test_load_miss(10'h004, "miss_004");
      test_load_hit(10'h005, "hit_005");
      test_store(10'h006, 32'hDEAD_BEEF, "st_hit_006");
      test_load_hit(10'h006, "hit_006");
      test_store(10'h100, 32'hCAFE_F00D, "st_miss_100");
      test_load_miss(10'h100, "miss_100");
      test_load_miss(10'h000, "miss_000");
      test_load_miss(10'h080, "miss_080");
      test_load_miss(10'h000, "remiss_000");
      test_load_hit(10'h003, "hit_003");
      test_reset_mid_miss();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
